syscall_unit: RTL and testbench

Syscall service unit: the responder side of the datapath's `syscall` request. It accepts a request code ($v0) and argument ($a0), stalls the core while servicing, and emits console bytes over a valid/ready byte stream. It reads string bytes through a word-read memory port, keeps the heap break pointer, and writes the sbrk result back to $v0. It sits beside the datapath and arbitrates the data-memory read port while busy.

---
 rtl/syscall_pkg.sv | 21 ++
 rtl/syscall_unit_hex_ascii.sv | 15 +
 rtl/syscall_unit.sv | 204 ++++++++++++++++++++
 tb/tb_syscall_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared constants and the FSM state type for the syscall service unit.
package syscall_pkg;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_PRINT_STR = 32'd4;
    localparam logic [31:0] SYS_SBRK      = 32'd9;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    localparam logic [7:0] ASCII_NL = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_EMIT,
        S_STR_FETCH,
        S_STR_EMIT,
        S_SBRK,
        S_DONE,
        S_HALT
    } state_e;

endpackage

// File: rtl/syscall_unit_hex_ascii.sv
// Combinational nibble to lowercase hex ASCII character.
module hex_ascii (
    input  logic [3:0] nib,
    output logic [7:0] ascii
);

    always_comb begin
        if (nib < 4'd10) begin
            ascii = 8'h30 + {4'h0, nib};
        end else begin
            ascii = 8'h57 + {4'h0, nib};
        end
    end

endmodule

// File: rtl/syscall_unit.sv
// Syscall responder: print-int, print-string, sbrk and exit, stalling the core while busy.
// Optional simulation trace of accepted requests (and $finish after exit) with SYSCALL_TRACE_EN.
//
// state       | meaning
// S_IDLE      | waiting for req_valid, dispatch on code
// S_INT_EMIT  | streaming 8 hex digits of arg then newline
// S_STR_FETCH | word read of the string byte at ptr
// S_STR_EMIT  | streaming the fetched byte
// S_SBRK      | returning old heap pointer to $v0, bumping heap
// S_DONE      | one-cycle done pulse, core advances
// S_HALT      | exit taken, stall forever until reset
module syscall_unit
    import syscall_pkg::*;
#(
    parameter logic [31:0] HEAP_BASE   = 32'h0000_0080,
    parameter int          MAX_STR_LEN = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] req_code,
    input  logic [31:0] req_arg,
    output logic        busy,
    output logic        done,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic        err
);

    localparam int CNT_W = ($clog2(MAX_STR_LEN + 1) > 4) ? $clog2(MAX_STR_LEN + 1) : 4;

    state_e            state_q, state_d;
    logic [31:0]       arg_q, arg_d;
    logic [31:0]       ptr_q, ptr_d;
    logic [31:0]       heap_q, heap_d;
    logic [7:0]        byte_q, byte_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        hex_char;
    logic [7:0]        lane_byte;
    logic              busy_c;
    logic              err_c;

    // arg_q is shifted left per digit, so the current digit is always the top nibble
    hex_ascii u_hex (
        .nib   (arg_q[31:28]),
        .ascii (hex_char)
    );

    always_comb begin
        case (ptr_q[1:0])
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            arg_q   <= '0;
            ptr_q   <= '0;
            heap_q  <= HEAP_BASE;
            byte_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            ptr_q   <= ptr_d;
            heap_q  <= heap_d;
            byte_q  <= byte_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        arg_d    = arg_q;
        ptr_d    = ptr_q;
        heap_d   = heap_q;
        byte_d   = byte_q;
        cnt_d    = cnt_q;
        busy_c   = 1'b0;
        err_c    = 1'b0;
        done     = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = '0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        tx_valid = 1'b0;
        tx_data  = '0;
        halt     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    busy_c = 1'b1;
                    arg_d  = req_arg;
                    ptr_d  = req_arg;
                    case (req_code)
                        SYS_PRINT_INT: begin
                            state_d = S_INT_EMIT;
                            cnt_d   = CNT_W'(9);
                        end
                        SYS_PRINT_STR: begin
                            state_d = S_STR_FETCH;
                            cnt_d   = CNT_W'(MAX_STR_LEN);
                        end
                        SYS_SBRK: state_d = S_SBRK;
                        SYS_EXIT: state_d = S_HALT;
                        default: begin
                            err_c   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            // cnt_q counts bytes still to send; the last one is the newline
            S_INT_EMIT: begin
                busy_c   = 1'b1;
                tx_valid = 1'b1;
                tx_data  = (cnt_q == CNT_W'(1)) ? ASCII_NL : hex_char;
                if (tx_ready) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    arg_d = {arg_q[27:0], 4'h0};
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_STR_FETCH: begin
                busy_c   = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = {ptr_q[31:2], 2'b00};
                if (mem_rvalid) begin
                    byte_d  = lane_byte;
                    state_d = (lane_byte == 8'h00) ? S_DONE : S_STR_EMIT;
                end
            end

            S_STR_EMIT: begin
                busy_c   = 1'b1;
                tx_valid = 1'b1;
                tx_data  = byte_q;
                if (tx_ready) begin
                    ptr_d   = ptr_q + 32'd1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? S_DONE : S_STR_FETCH;
                end
            end

            S_SBRK: begin
                busy_c   = 1'b1;
                rf_we    = 1'b1;
                rf_wdata = heap_q;
                heap_d   = heap_q + ((arg_q + 32'd3) & ~32'd3);
                state_d  = S_DONE;
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            S_HALT: begin
                busy_c = 1'b1;
                halt   = 1'b1;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // request-driven outputs must read 0 while reset is held even with req_valid high
    assign busy = busy_c & reset;
    assign err  = err_c & reset;

`ifdef SYSCALL_TRACE_EN
    always @(posedge clk) begin
        if (reset) begin
            if (state_q == S_IDLE && req_valid) begin
                $display("syscall code=%0d arg=0x%08h", req_code, req_arg);
            end
            if (state_q == S_SBRK) begin
                $display("syscall sbrk returns 0x%08h", heap_q);
            end
            if (state_q == S_HALT) begin
                $finish;
            end
        end
    end
`endif

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: transaction-level model plus directed literal expectations.
module tb_syscall_unit;

    localparam logic [31:0] HB   = 32'h0000_0080;
    localparam int          MAXS = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_code = '0;
    logic [31:0] req_arg = '0;
    logic        busy, done, rf_we, mem_rd, tx_valid, halt, err;
    logic [31:0] rf_wdata, mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    always #5 clk = ~clk;

    syscall_unit #(.HEAP_BASE(HB), .MAX_STR_LEN(MAXS)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .req_arg    (req_arg),
        .busy       (busy),
        .done       (done),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .halt       (halt),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_rf[$];
    logic [7:0]  got_bytes[$];
    logic [31:0] mdl_heap = HB;

    int          tx_cnt = 0, rf_cnt = 0, done_cnt = 0, err_cnt = 0, mem_cnt = 0;
    logic [31:0] last_rf = '0;
    logic [31:0] last_addr = '0;
    bit          rand_stall = 1'b0;
    bit          tx_hold = 1'b0, mem_hold = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // byte-addressed memory image; one word holds "ABC\0", everything else is lowercase letters
    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h100: return 8'h41;
            32'h101: return 8'h42;
            32'h102: return 8'h43;
            32'h103: return 8'h00;
            default: return 8'h61 + 8'(a % 32'd26);
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] b;
        b = {a[31:2], 2'b00};
        return {byte_at(b + 32'd3), byte_at(b + 32'd2), byte_at(b + 32'd1), byte_at(b)};
    endfunction

    function automatic bit known_code(input logic [31:0] code);
        return (code == 32'd1) || (code == 32'd4) || (code == 32'd9) || (code == 32'd10);
    endfunction

    function automatic void model_req(input logic [31:0] code, input logic [31:0] arg);
        logic [31:0] p;
        logic [3:0]  n;
        logic [7:0]  b;
        if (code == 32'd1) begin
            for (int i = 7; i >= 0; i--) begin
                n = 4'((arg >> (4 * i)) & 32'hF);
                exp_bytes.push_back((n < 4'd10) ? (8'h30 + 8'(n)) : (8'h61 + 8'(n) - 8'd10));
            end
            exp_bytes.push_back(8'h0A);
        end else if (code == 32'd4) begin
            p = arg;
            for (int k = 0; k < MAXS; k++) begin
                b = byte_at(p);
                exp_addr.push_back({p[31:2], 2'b00});
                if (b == 8'h00) break;
                exp_bytes.push_back(b);
                p = p + 32'd1;
            end
        end else if (code == 32'd9) begin
            exp_rf.push_back(mdl_heap);
            mdl_heap = mdl_heap + ((arg + 32'd3) & ~32'd3);
        end
    endfunction

    // environment: console and memory responders
    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mem_rd) begin
                mem_rvalid = rand_stall ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_rdata  = word_at(mem_addr);
            end else begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = 32'h0;
            end
        end
    end

    // per-cycle compare against the model queues
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rf", {rf_we, rf_wdata}, 0);
            chk("rst_mem", {mem_rd, mem_addr}, 0);
            chk("rst_tx", {tx_valid, tx_data}, 0);
            chk("rst_halt_err", {halt, err}, 0);
            tx_hold  = 1'b0;
            mem_hold = 1'b0;
        end else begin
            if (tx_hold) chk("tx_valid_held", tx_valid, 1);
            if (mem_hold) chk("mem_rd_held", mem_rd, 1);
            if (tx_valid) begin
                if (exp_bytes.size() == 0) chk("tx_unexpected", {tx_valid, tx_data}, 0);
                else chk("tx_data", tx_data, exp_bytes[0]);
                if (tx_ready) begin
                    if (exp_bytes.size() != 0) void'(exp_bytes.pop_front());
                    got_bytes.push_back(tx_data);
                    tx_cnt++;
                end
            end
            tx_hold = tx_valid && !tx_ready;
            if (mem_rd) begin
                if (exp_addr.size() == 0) chk("mem_unexpected", {mem_rd, mem_addr}, 0);
                else chk("mem_addr", mem_addr, exp_addr[0]);
                if (mem_rvalid) begin
                    if (exp_addr.size() != 0) void'(exp_addr.pop_front());
                    last_addr = mem_addr;
                    mem_cnt++;
                end
            end
            mem_hold = mem_rd && !mem_rvalid;
            if (rf_we) begin
                if (exp_rf.size() == 0) chk("rf_unexpected", {rf_we, rf_wdata}, 0);
                else chk("rf_wdata", rf_wdata, exp_rf.pop_front());
                last_rf = rf_wdata;
                rf_cnt++;
            end
            if (done) begin
                done_cnt++;
                chk("done_not_busy", busy, 0);
            end
            if (err) err_cnt++;
        end
    end

    // called at posedge+1 while idle; returns at posedge+1 of the done cycle
    task automatic do_req(input logic [31:0] code, input logic [31:0] arg, input int limit,
                          output int n);
        bit seen;
        model_req(code, arg);
        req_code  = code;
        req_arg   = arg;
        req_valid = 1'b1;
        #1;
        chk("busy_on_req", busy, 1);
        chk("err_on_req", err, !known_code(code));
        n    = 0;
        seen = 1'b0;
        while (n < limit && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL timeout code %0d: no done after %0d cycles", code, n);
        end
        req_valid = 1'b0;
        chk("exp_bytes_left", exp_bytes.size(), 0);
        chk("exp_addr_left", exp_addr.size(), 0);
        chk("exp_rf_left", exp_rf.size(), 0);
    endtask

    task automatic idle_gap();
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("idle_busy_done", {busy, done}, 0);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        exp_bytes.delete();
        exp_addr.delete();
        exp_rf.delete();
        mdl_heap = HB;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_tx", {tx_valid, tx_data}, 0);
        chk("arst_halt", halt, 0);
        chk("arst_mem", {mem_rd, mem_addr}, 0);
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
    endtask

    int    n, s_tx, s_rf, s_done, s_err, s_mem;
    string hexs;

    initial begin
        hexs = "deadbeef";
        // reset held with a pending unknown request: nothing may leak out
        req_valid = 1'b1;
        req_code  = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        chk("por_busy", busy, 0);
        chk("por_err", err, 0);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        do_req(32'd9, 32'd10, 20, n);
        chk("sbrk1_lat", n, 2);
        chk("sbrk1_ret", last_rf, 32'h80);
        idle_gap();
        do_req(32'd9, 32'd4, 20, n);
        chk("sbrk2_ret", last_rf, 32'h8C);
        idle_gap();
        do_req(32'd9, 32'd0, 20, n);
        chk("sbrk3_ret", last_rf, 32'h90);
        idle_gap();

        got_bytes.delete();
        s_done = done_cnt;
        do_req(32'd1, 32'hDEAD_BEEF, 40, n);
        chk("pint_lat", n, 10);
        idle_gap();
        chk("pint_one_done", done_cnt - s_done, 1);
        chk("pint_len", got_bytes.size(), 9);
        for (int i = 0; i < 8; i++) chk("pint_char", got_bytes[i], hexs[i]);
        chk("pint_nl", got_bytes[8], 8'h0A);

        got_bytes.delete();
        s_tx  = tx_cnt;
        s_mem = mem_cnt;
        do_req(32'd4, 32'h102, 40, n);
        chk("pstr_lat", n, 4);
        chk("pstr_bytes", tx_cnt - s_tx, 1);
        chk("pstr_char", got_bytes[0], 8'h43);
        chk("pstr_reads", mem_cnt - s_mem, 2);
        chk("pstr_addr", last_addr, 32'h100);
        idle_gap();

        s_tx  = tx_cnt;
        s_rf  = rf_cnt;
        s_err = err_cnt;
        do_req(32'd7, 32'h1234, 20, n);
        chk("unk_lat", n, 1);
        chk("unk_err", err_cnt - s_err, 1);
        chk("unk_no_side", {16'(tx_cnt - s_tx), 16'(rf_cnt - s_rf)}, 0);
        idle_gap();

        rand_stall = 1'b1;
        s_tx  = tx_cnt;
        s_mem = mem_cnt;
        do_req(32'd4, 32'hFFFF_FF81, 6000, n);
        chk("long_bytes", tx_cnt - s_tx, 256);
        chk("long_reads", mem_cnt - s_mem, 256);
        idle_gap();
        got_bytes.delete();
        do_req(32'd1, 32'h0123_4567, 200, n);
        chk("pint2_first", got_bytes[0], 8'h30);
        chk("pint2_last_digit", got_bytes[7], 8'h37);
        rand_stall = 1'b0;
        idle_gap();

        do_req(32'd9, 32'd5, 20, n);
        chk("sbrk4_ret", last_rf, 32'h90);
        idle_gap();
        do_req(32'd9, 32'd0, 20, n);
        chk("sbrk5_ret", last_rf, 32'h98);
        idle_gap();

        // reset in the middle of print-int, request still asserted
        s_tx = tx_cnt;
        model_req(32'd1, 32'hCAFE_F00D);
        req_code  = 32'd1;
        req_arg   = 32'hCAFE_F00D;
        req_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (tx_cnt - s_tx >= 3) break;
        end
        chk("mid_bytes", tx_cnt - s_tx, 3);
        #2;
        apply_reset();
        do_req(32'd9, 32'd0, 20, n);
        chk("post_rst_lat", n, 2);
        chk("post_rst_heap", last_rf, 32'h80);
        idle_gap();

        s_done = done_cnt;
        req_code  = 32'd10;
        req_arg   = 32'd0;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            chk("halt_hold", {busy, halt}, 2'b11);
        end
        chk("halt_no_done", done_cnt - s_done, 0);
        apply_reset();
        do_req(32'd9, 32'd4, 20, n);
        chk("post_halt_heap", last_rf, 32'h80);
        idle_gap();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
